// File: rtl/axi_master_bridge_pkg.sv
// Shared AXI4 widths, fixed field encodings and response helpers for the
// initiator-side master bridge.
package axi_master_bridge_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  localparam logic [1:0]               AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Responses are ranked by their encoding: a larger code is a worse outcome.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// Single-command AXI4 initiator: one INCR burst of 32-bit beats per request,
// data streamed straight through between core and bus with no buffering.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESET,
  // core command port
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WRITE,
  input  logic [AXI_ADDR_BITS-1:0] REQ_ADDR,
  input  logic [AXI_LEN_BITS-1:0]  REQ_LEN,
  input  logic [AXI_ID_BITS-1:0]   REQ_ID,
  // core write-data stream
  input  logic [AXI_DATA_BITS-1:0] WD_DATA,
  input  logic [AXI_STRB_BITS-1:0] WD_STRB,
  input  logic                     WD_VALID,
  output logic                     WD_READY,
  // core read-data stream
  output logic [AXI_DATA_BITS-1:0] RD_DATA,
  output logic                     RD_LAST,
  output logic                     RD_VALID,
  input  logic                     RD_READY,
  // completion
  output logic                     DONE,
  output logic [1:0]               DONE_RESP,
  // AXI read address
  output logic [AXI_ID_BITS-1:0]   ARID_M,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_M,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_M,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_M,
  output logic [1:0]               ARBURST_M,
  output logic                     ARVALID_M,
  input  logic                     ARREADY_M,
  // AXI read data
  input  logic [AXI_ID_BITS-1:0]   RID_M,
  input  logic [AXI_DATA_BITS-1:0] RDATA_M,
  input  logic [1:0]               RRESP_M,
  input  logic                     RLAST_M,
  input  logic                     RVALID_M,
  output logic                     RREADY_M,
  // AXI write address
  output logic [AXI_ID_BITS-1:0]   AWID_M,
  output logic [AXI_ADDR_BITS-1:0] AWADDR_M,
  output logic [AXI_LEN_BITS-1:0]  AWLEN_M,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE_M,
  output logic [1:0]               AWBURST_M,
  output logic                     AWVALID_M,
  input  logic                     AWREADY_M,
  // AXI write data
  output logic [AXI_DATA_BITS-1:0] WDATA_M,
  output logic [AXI_STRB_BITS-1:0] WSTRB_M,
  output logic                     WLAST_M,
  output logic                     WVALID_M,
  input  logic                     WREADY_M,
  // AXI write response
  input  logic [AXI_ID_BITS-1:0]   BID_M,
  input  logic [1:0]               BRESP_M,
  input  logic                     BVALID_M,
  output logic                     BREADY_M
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t                   r_state;
  logic [AXI_ID_BITS-1:0]   r_id;
  logic [AXI_ADDR_BITS-1:0] r_addr;
  logic [AXI_LEN_BITS-1:0]  r_len;
  logic [AXI_LEN_BITS-1:0]  r_beat;
  logic [1:0]               r_worst;
  logic                     r_err;
  logic                     r_done;
  logic [1:0]               r_done_resp;

  logic       w_idle, w_ar, w_r, w_aw, w_w, w_b;
  logic       w_at_len;
  logic       w_r_err;
  logic [1:0] w_r_resp;
  logic [1:0] w_b_resp;
  logic       w_unused;

  // State decodes are masked by reset so every handshake output is low while
  // ARESET is held, even before the first reset edge has been seen.
  assign w_idle = !ARESET && (r_state == S_IDLE);
  assign w_ar   = !ARESET && (r_state == S_AR);
  assign w_r    = !ARESET && (r_state == S_R);
  assign w_aw   = !ARESET && (r_state == S_AW);
  assign w_w    = !ARESET && (r_state == S_W);
  assign w_b    = !ARESET && (r_state == S_B);

  assign w_at_len = (r_beat == r_len);
  // A beat whose RLAST disagrees with the beat count marks the burst bad.
  assign w_r_err  = r_err || (RLAST_M != w_at_len);
  assign w_r_resp = resp_max(r_worst, RRESP_M);
  assign w_b_resp = resp_max(r_worst, BRESP_M);
  assign w_unused = ^{RID_M, BID_M};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_worst     <= AXI_RESP_OKAY;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_done_resp <= '0;
    end else begin
      r_done      <= 1'b0;
      r_done_resp <= '0;
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_id    <= REQ_ID;
            r_addr  <= REQ_ADDR;
            r_len   <= REQ_LEN;
            r_beat  <= '0;
            r_worst <= AXI_RESP_OKAY;
            r_err   <= 1'b0;
            r_state <= REQ_WRITE ? S_AW : S_AR;
          end
        end
        S_AR: begin
          if (ARREADY_M) r_state <= S_R;
        end
        S_R: begin
          if (RVALID_M && RD_READY) begin
            r_beat  <= r_beat + 4'd1;
            r_worst <= w_r_resp;
            r_err   <= w_r_err;
            if (RLAST_M) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_done_resp <= w_r_err ? AXI_RESP_SLVERR : w_r_resp;
            end
          end
        end
        S_AW: begin
          if (AWREADY_M) r_state <= S_W;
        end
        S_W: begin
          if (WD_VALID && WREADY_M) begin
            r_beat <= r_beat + 4'd1;
            if (w_at_len) r_state <= S_B;
          end
        end
        S_B: begin
          if (BVALID_M) begin
            r_worst     <= w_b_resp;
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_done_resp <= w_b_resp;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY = w_idle;

  assign ARID_M    = r_id;
  assign ARADDR_M  = r_addr;
  assign ARLEN_M   = r_len;
  assign ARSIZE_M  = AXI_SIZE_4B;
  assign ARBURST_M = AXI_BURST_INCR;
  assign ARVALID_M = w_ar;

  assign RREADY_M  = w_r && RD_READY;
  assign RD_VALID  = w_r && RVALID_M;
  assign RD_DATA   = w_r ? RDATA_M : '0;
  assign RD_LAST   = w_r && RLAST_M;

  assign AWID_M    = r_id;
  assign AWADDR_M  = r_addr;
  assign AWLEN_M   = r_len;
  assign AWSIZE_M  = AXI_SIZE_4B;
  assign AWBURST_M = AXI_BURST_INCR;
  assign AWVALID_M = w_aw;

  assign WVALID_M  = w_w && WD_VALID;
  assign WD_READY  = w_w && WREADY_M;
  assign WDATA_M   = w_w ? WD_DATA : '0;
  assign WSTRB_M   = w_w ? WD_STRB : '0;
  assign WLAST_M   = w_w && w_at_len;

  assign BREADY_M  = w_b;

  assign DONE      = r_done;
  assign DONE_RESP = r_done_resp;

endmodule

// File: doc/axi_master_bridge.md
# axi_master_bridge

Initiator-side AXI4 engine that turns single-command memory requests from a core or cache into one AXI read or write burst, at the opposite end of the bus from the SRAM slave wrappers. Sits between the CPU/cache request port and one master port of the AXI bridge. Moves one transaction at a time, with INCR bursts of 32-bit beats. Write data and read data stream through with handshakes and are not buffered.

## Interface
Parameters: none. All widths come from the `AXI_define.svh` macros: `AXI_ID_BITS`=4, `AXI_ADDR_BITS`=32, `AXI_LEN_BITS`=4, `AXI_SIZE_BITS`=3, `AXI_DATA_BITS`=32, `AXI_STRB_BITS`=4.
- ACLK  in  1  clock; one clock domain
- ARESET  in  1  synchronous, active-high reset
- REQ_VALID / REQ_READY  in/out  1/1  command handshake
- REQ_WRITE  in  1  1 = write burst, 0 = read burst
- REQ_ADDR  in  32  byte address, word aligned
- REQ_LEN  in  4  number of beats minus 1
- REQ_ID  in  4  transaction ID, driven on ARID_M/AWID_M
- WD_DATA, WD_STRB, WD_VALID / WD_READY  in,in,in/out  32,4,1/1  core write-data stream
- RD_DATA, RD_LAST, RD_VALID / RD_READY  out,out,out/in  32,1,1/1  core read-data stream
- DONE  out  1  one-cycle completion pulse
- DONE_RESP  out  2  worst response seen in the burst; valid while DONE = 1
- ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M / ARREADY_M  AXI read-address channel
- RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M / RREADY_M  AXI read-data channel
- AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M / AWREADY_M  AXI write-address channel
- WDATA_M, WSTRB_M, WLAST_M, WVALID_M / WREADY_M  AXI write-data channel
- BID_M, BRESP_M, BVALID_M / BREADY_M  AXI write-response channel

## Operation
States:
- IDLE, AR, R, AW, W, B.

Transitions:
- IDLE: REQ_READY = 1. On REQ_VALID, latch ID, ADDR and LEN, then go to AW if REQ_WRITE = 1, else AR. Clear beat_cnt and clear worst_resp to OKAY.
- AR: ARVALID_M = 1, with address fields taken from the latched registers. Go to R on ARREADY_M.
- R: RREADY_M = RD_READY and RD_VALID = RVALID_M, both gated by state. RD_DATA = RDATA_M and RD_LAST = RLAST_M. Each beat handshake increments beat_cnt and sets worst_resp to max(worst_resp, RRESP_M). Go to IDLE on the handshake where RLAST_M = 1.
- AW: AWVALID_M = 1. Go to W on AWREADY_M. No W beat is issued before AW completes.
- W: WVALID_M = WD_VALID and WD_READY = WREADY_M, both gated by state. WDATA_M/WSTRB_M pass through from the core stream. WLAST_M = (beat_cnt == len). Go to B on the handshake where WLAST_M = 1.
- B: BREADY_M = 1. On BVALID_M, set worst_resp to max(worst_resp, BRESP_M), then go to IDLE.

Fixed field values and width rules:
- ARSIZE_M/AWSIZE_M = 3'b010. ARBURST_M/AWBURST_M = INCR (2'b01).
- beat_cnt is 4 bits. It wraps only after the 16th beat, and it is never compared beyond len.

Protocol error:
- If RLAST_M arrives at beat_cnt != len, or RLAST_M is missing at beat_cnt == len, the burst still ends on RLAST_M. DONE_RESP is then forced to SLVERR (2'b10).

Completion:
- DONE is a registered pulse in the cycle after the final R or B handshake, with the FSM already in IDLE.
- A new REQ_VALID may be accepted in that same cycle.

## Timing
Reset:
- ARESET is sampled at the ACLK edge. State returns to IDLE.
- Every output is 0 during reset: all VALID/READY/LAST signals, DONE, DONE_RESP, and all M-side address, ID and data fields. The exception is that ARSIZE_M/AWSIZE_M/ARBURST_M/AWBURST_M may hold their constant values.
- Reset in the middle of a burst drops all VALIDs in the next cycle. No response is produced.

Read latency, best case:
- Command accepted at edge 0, ARVALID_M high in cycle 1, ARREADY_M in cycle 1. The first R beat can be accepted in cycle 2.

Write latency, best case:
- AW in cycle 1, first W beat in cycle 2, B in cycle 2+LEN+1.

Handshake rules:
- AxVALID and the address fields stay stable until READY.
- Backpressure is combinational in both directions (RD_READY to RREADY_M, WREADY_M to WD_READY). There is no added bubble and no skid buffer.

Simultaneous events:
- REQ_VALID is ignored outside IDLE.
- RVALID_M/BVALID_M are ignored outside R/B.

## Structure
- Width macros, AXI_BURST_INCR, AXI_SIZE_4B and AXI_RESP_* are shared constants in AXI_define.svh. Add AXI_BURST_INCR and AXI_SIZE_4B there if they are absent.
- The state enum is local to the module.
- Single flat module with no sub-module. It holds the FSM, the latched command registers, beat_cnt, worst_resp and the DONE register.

## Test plan
- Read, LEN=0, addr 0x0000_0010, slave returns 0xDEAD_BEEF with OKAY -> ARLEN_M=0; RD_DATA=0xDEAD_BEEF with RD_LAST=1; DONE pulses once with DONE_RESP=2'b00.
- Read, LEN=3, RD_READY low for 2 cycles on beat 1 -> RREADY_M low for the same cycles; 4 beats delivered in order; RD_LAST only on beat 3.
- Write, LEN=1, data 0x1111_1111 and 0x2222_2222, WSTRB=4'b0011, AWREADY delayed 3 cycles -> no WVALID_M before the AW handshake; WLAST_M on beat 1; DONE after B.
- Read, LEN=2, slave RRESP=SLVERR on beat 1 only -> DONE_RESP=2'b10. Separately, RLAST_M early on beat 1 -> burst ends and DONE_RESP=2'b10.
- ARESET asserted mid-W burst (beat 2 of 4) -> next cycle WVALID_M=0 and REQ_READY=1; a new read then completes normally.
- Back-to-back: second REQ_VALID held high through DONE -> accepted in the DONE cycle; ARVALID_M in the next cycle.
